muldiv_64: RTL
==============

MULDIV_64 -- requirements
Module: muldiv_64

Interface
REQ-001 The block SHALL have one clock; reset is synchronous and active-high.
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 start  input  1  request; accepted only when busy=0.
REQ-005 op  input  3  RISC-V M funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-006 rs1Data  input  64  operand A, from register-file read port 1.
REQ-007 rs2Data  input  64  operand B, from register-file read port 2.
REQ-008 rdIn  input  5  destination register number.
REQ-009 busy  output  1  high while an operation is iterating.
REQ-010 done  output  1  one-cycle pulse: result and rdOut are valid.
REQ-011 result  output  64  write data for the register-file write port.
REQ-012 rdOut  output  5  destination register, latched at accept.
REQ-013 regWrite  output  1  equals done; drives the register-file write enable.

Function
REQ-014 States SHALL be IDLE, CALC and DONE.
REQ-015 A start in IDLE or DONE SHALL latch op, rs1Data, rs2Data and rdIn; later input changes SHALL have no effect on the operation.
REQ-016 A start while busy=1 SHALL be ignored without error.
REQ-017 Normal accept SHALL go to CALC for exactly 64 cycles, then to DONE; done is high in the 65th cycle after the accept edge.
REQ-018 MUL-class ops SHALL use 64 shift-add iterations on operand magnitudes into a 128-bit accumulator, then apply sign fix-up.
REQ-019 Signedness SHALL be: MULH signed x signed; MULHSU signed rs1 x unsigned rs2; MULHU unsigned x unsigned.
REQ-020 MUL SHALL return product[63:0]; MULH, MULHSU and MULHU SHALL return product[127:64].
REQ-021 DIV-class ops SHALL use 64 restoring iterations on magnitudes.
REQ-022 Quotient SHALL truncate toward zero; remainder SHALL take the sign of the dividend.
REQ-023 Divide by zero SHALL skip CALC and go IDLE/DONE -> DONE directly, with done one cycle after accept; DIV/DIVU give all-ones, REM/REMU give rs1.
REQ-024 Signed overflow (rs1 = 0x8000_0000_0000_0000, rs2 = -1) SHALL take the same 1-cycle path; DIV gives rs1, REM gives 0.
REQ-025 In DONE, done SHALL be high for exactly one cycle; with no new start the block SHALL return to IDLE.
REQ-026 A start in DONE SHALL be accepted in that same cycle (back-to-back issue).
REQ-027 result and rdOut SHALL hold their value until the next completion.
REQ-028 busy SHALL be high in CALC only.

Reset
REQ-029 Reset SHALL force IDLE with busy=0, done=0, regWrite=0, result=0 and rdOut=0.
REQ-030 Reset SHALL take priority over start.
REQ-031 Reset during CALC SHALL abort the operation with no done pulse and no regWrite.

Structure
REQ-032 Package riscv_m_pkg SHALL hold the muldiv_op_t enum (funct3 codes), the muldiv_state_t enum, XLEN=64 and ITERS=64.
REQ-033 The block SHALL be a single module; no sub-module is needed; one shared 64-bit adder/subtractor SHALL serve both iteration types.

Verification
REQ-034 MUL 7 x -3 -> result 0xFFFF_FFFF_FFFF_FFEB, done exactly 65 cycles after accept, rdOut = rdIn.
REQ-035 MULHU 0xFFFF_FFFF_FFFF_FFFF x 0xFFFF_FFFF_FFFF_FFFF -> 0xFFFF_FFFF_FFFF_FFFE; MULH of the same operands -> 0.
REQ-036 DIV -7/2 -> 0xFFFF_FFFF_FFFF_FFFD; REM -7/2 -> 0xFFFF_FFFF_FFFF_FFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2.
REQ-037 DIVU 42/0 -> 0xFFFF_FFFF_FFFF_FFFF; REMU 42/0 -> 42; DIV 0x8000_0000_0000_0000 / -1 -> 0x8000_0000_0000_0000; REM of the same -> 0; each with done 1 cycle after accept.
REQ-038 A start with different operands at CALC cycle 10 SHALL be ignored, giving the first result; reset at CALC cycle 30 -> busy=0 next cycle and no done pulse.
REQ-039 A start in the DONE cycle SHALL be accepted; the second done pulse SHALL occur 65 cycles later.

Source files
------------

// File: rtl/riscv_m_pkg.sv
// Shared types for the RV64 M-extension multiply/divide unit.
// Operation codes match the funct3 field so op can be cast directly.
package riscv_m_pkg;

    localparam int XLEN  = 64;
    localparam int ITERS = 64;

    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } muldiv_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } muldiv_state_t;

    function automatic logic op_is_div(input muldiv_op_t f);
        return f[2];
    endfunction

endpackage

// File: rtl/muldiv_64.sv
// Iterative RV64 M-unit: 64-cycle shift-add multiply / restoring divide, done in cycle 65;
// divide-by-zero and signed overflow finish in 1 cycle. Starts while busy are dropped.
module muldiv_64
    import riscv_m_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] rs1Data,
    input  logic [XLEN-1:0] rs2Data,
    input  logic [4:0]      rdIn,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result,
    output logic [4:0]      rdOut,
    output logic            regWrite
);

    localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

    muldiv_state_t state, state_nxt;

    muldiv_op_t      op_in;
    logic            accept;
    logic            in_sgn_a, in_sgn_b;
    logic            a_neg, b_neg;
    logic [XLEN-1:0] a_mag, b_mag;
    logic            div_zero, div_ovf, fast;
    logic [XLEN-1:0] fast_result;

    muldiv_op_t      op_q;
    logic            res_neg_q, rem_neg_q;
    logic [XLEN-1:0] b_q, hi_q, lo_q;
    logic [5:0]      cnt_q;
    logic [4:0]      rd_q;
    logic            last;

    logic            is_div_q;
    logic [XLEN-1:0] add_a, add_b;
    logic            add_cin;
    logic [XLEN:0]   sum;
    logic            ge;
    logic [XLEN-1:0] hi_nxt, lo_nxt;
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0] quot_fix, rem_fix, calc_result;

    // ---------------- input decode at accept ----------------
    assign op_in  = muldiv_op_t'(op);
    assign accept = start && (state != CALC);

    always_comb begin
        in_sgn_a = (op_in == OP_MUL) || (op_in == OP_MULH) || (op_in == OP_MULHSU) ||
                   (op_in == OP_DIV) || (op_in == OP_REM);
        in_sgn_b = (op_in == OP_MUL) || (op_in == OP_MULH) ||
                   (op_in == OP_DIV) || (op_in == OP_REM);
        a_neg    = in_sgn_a && rs1Data[XLEN-1];
        b_neg    = in_sgn_b && rs2Data[XLEN-1];
        a_mag    = a_neg ? -rs1Data : rs1Data;
        b_mag    = b_neg ? -rs2Data : rs2Data;
        div_zero = op_is_div(op_in) && (rs2Data == '0);
        div_ovf  = ((op_in == OP_DIV) || (op_in == OP_REM)) &&
                   (rs1Data == INT_MIN) && (rs2Data == '1);
        fast     = div_zero || div_ovf;

        fast_result = '0;
        if (div_zero)
            fast_result = op_in[1] ? rs1Data : '1;
        else if (div_ovf)
            fast_result = op_in[1] ? '0 : rs1Data;
    end

    // ---------------- shared iteration datapath ----------------
    // Divide trial-subtracts via the same adder using ~divisor + 1.
    assign is_div_q = op_is_div(op_q);
    assign last     = (cnt_q == 6'(ITERS - 1));

    always_comb begin
        add_a   = is_div_q ? {hi_q[XLEN-2:0], lo_q[XLEN-1]} : hi_q;
        add_b   = is_div_q ? ~b_q : (lo_q[0] ? b_q : '0);
        add_cin = is_div_q;
        sum     = {1'b0, add_a} + {1'b0, add_b} + {{XLEN{1'b0}}, add_cin};
        // A set bit shifted out of the remainder means it already exceeds any divisor.
        ge      = hi_q[XLEN-1] || sum[XLEN];

        if (is_div_q) begin
            hi_nxt = ge ? sum[XLEN-1:0] : add_a;
            lo_nxt = {lo_q[XLEN-2:0], ge};
        end else begin
            hi_nxt = sum[XLEN:1];
            lo_nxt = {sum[0], lo_q[XLEN-1:1]};
        end

        prod_fix = res_neg_q ? -{hi_nxt, lo_nxt} : {hi_nxt, lo_nxt};
        quot_fix = res_neg_q ? -lo_nxt : lo_nxt;
        rem_fix  = rem_neg_q ? -hi_nxt : hi_nxt;

        calc_result = '0;
        case (op_q)
            OP_MUL:                        calc_result = prod_fix[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU:  calc_result = prod_fix[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU:               calc_result = quot_fix;
            OP_REM, OP_REMU:               calc_result = rem_fix;
            default:                       calc_result = '0;
        endcase
    end

    // ---------------- control FSM ----------------
    always_ff @(posedge clk) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE, DONE: begin
                done = (state == DONE);
                if (accept)
                    state_nxt = fast ? DONE : CALC;
                else
                    state_nxt = IDLE;
            end
            CALC: begin
                busy = 1'b1;
                if (last)
                    state_nxt = DONE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign regWrite = done;

    // ---------------- operand / result registers ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            op_q      <= OP_MUL;
            res_neg_q <= 1'b0;
            rem_neg_q <= 1'b0;
            b_q       <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            cnt_q     <= '0;
            rd_q      <= '0;
            result    <= '0;
            rdOut     <= '0;
        end else if (accept) begin
            op_q      <= op_in;
            res_neg_q <= a_neg ^ b_neg;
            rem_neg_q <= a_neg;
            b_q       <= b_mag;
            hi_q      <= '0;
            lo_q      <= a_mag;
            cnt_q     <= '0;
            rd_q      <= rdIn;
            if (fast) begin
                result <= fast_result;
                rdOut  <= rdIn;
            end
        end else if (state == CALC) begin
            hi_q  <= hi_nxt;
            lo_q  <= lo_nxt;
            cnt_q <= cnt_q + 6'd1;
            if (last) begin
                result <= calc_result;
                rdOut  <= rd_q;
            end
        end
    end

endmodule
